// File: rtl/dma_periph_req_sched_if.sv
// dma_periph_req_sched_if: request/complete handshake between the scheduler and the DMA channel engine
interface dma_periph_req_sched_if #(parameter int IDX_W = 5);
  logic             xfer_valid;
  logic             xfer_ready;
  logic [IDX_W-1:0] xfer_periph;
  logic             xfer_done;
  logic             xfer_err;
  modport master (output xfer_valid, xfer_periph, input xfer_ready, xfer_done, xfer_err);
  modport slave  (input xfer_valid, xfer_periph, output xfer_ready, xfer_done, xfer_err);
endinterface

// File: rtl/dma_periph_req_sched.sv
// dma_periph_req_sched: round-robin grant of one DMA channel among NUM_PERIPH request lines.
// Define DMA_SCHED_TIMEOUT_EN to build a BUSY watchdog that force-clears a stalled transfer.
module dma_periph_req_sched #(
  parameter int NUM_PERIPH = 31,
  parameter int IDX_W      = 5,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic [NUM_PERIPH:1]   i_req_mask,
  input  logic [NUM_PERIPH:1]   i_periph_req,
  output logic [NUM_PERIPH:1]   o_periph_clr,
  dma_periph_req_sched_if.master xfer,
  input  logic                  i_err_clr,
  output logic                  o_err_status,
  output logic                  o_idle
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_CLR} state_t;
  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_last_gnt, r_periph, w_sel;
  logic             r_hold, r_err, w_found, w_grant, w_err_set, w_tmo;
  logic [NUM_PERIPH:1] w_dec, w_pend;

  for (genvar g = 1; g <= NUM_PERIPH; g++) begin : g_dec
    assign w_dec[g] = r_periph == IDX_W'(g);
  end

  // the line just cleared is masked for one cycle so its level request can drop first
  assign w_pend       = i_periph_req & i_req_mask & ~(r_hold ? w_dec : '0);
  assign o_periph_clr = (r_state == S_CLR) ? w_dec : '0;
  assign xfer.xfer_valid  = r_state == S_ISSUE;
  assign xfer.xfer_periph = r_periph;
  assign o_err_status = r_err;
  assign o_idle       = r_state == S_IDLE;

`ifdef DMA_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo;
  // watchdog counts BUSY cycles; zero on the first BUSY cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_tmo <= '0;
    else        r_tmo <= (r_state == S_BUSY) ? r_tmo + 1'b1 : '0;
  end
  assign w_tmo = (r_state == S_BUSY) && (r_tmo == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_W;
  assign w_tmo        = 1'b0;
`endif

  // first pending line after the last grant, wrapping NUM_PERIPH -> 1
  always_comb begin
    int j;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_PERIPH; k++) begin
      j = int'(r_last_gnt) + k;
      if (j > NUM_PERIPH) j = j - NUM_PERIPH;
      if (!w_found && w_pend[IDX_W'(j)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
  end

  // next state, grant strobe and error capture at the completing edge
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: if (i_enable && w_found) begin
        w_grant = 1'b1;
        w_next  = S_ISSUE;
      end
      S_ISSUE: if (xfer.xfer_ready) begin
        w_next    = xfer.xfer_done ? S_CLR : S_BUSY;
        w_err_set = xfer.xfer_done & xfer.xfer_err;
      end
      S_BUSY: if (xfer.xfer_done) begin
        w_next    = S_CLR;
        w_err_set = xfer.xfer_err;
      end else if (w_tmo) begin
        w_next    = S_CLR;
        w_err_set = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state, grant bookkeeping and sticky error (set wins over clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last_gnt <= IDX_W'(NUM_PERIPH);
      r_periph   <= '0;
      r_hold     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= r_state == S_CLR;
      r_err   <= w_err_set | (r_err & ~i_err_clr);
      if (w_grant) begin
        r_periph   <= w_sel;
        r_last_gnt <= w_sel;
      end
    end
  end
endmodule

// File: tb/tb_dma_periph_req_sched.sv
// tb_dma_periph_req_sched: directed checks of grant order, handshake, clear pulse and error flag
module tb_dma_periph_req_sched;
  localparam int N = 31;
  logic clk = 0, reset = 0, enable = 0, err_clr = 0;
  logic [N:1] mask = '0, req = '0, clr;
  logic err_status, idle;
  int n_chk = 0, n_fail = 0;

  dma_periph_req_sched_if #(.IDX_W(5)) xif();

  dma_periph_req_sched #(.NUM_PERIPH(N), .IDX_W(5), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .i_enable(enable), .i_req_mask(mask), .i_periph_req(req),
    .o_periph_clr(clr), .xfer(xif.master), .i_err_clr(err_clr), .o_err_status(err_status), .o_idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bitv(input int i);
    return 32'(1) << (i - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0; req = '0; err_clr = 0;
    xif.xfer_ready = 0; xif.xfer_done = 0; xif.xfer_err = 0;
    tick; tick;
    reset = 1;
  endtask

  task automatic xfer(input string tag, input int exp, input int dly, input logic e, input logic ec);
    int n = 0;
    while (!xif.xfer_valid && n < 40) begin tick; n++; end
    chk({tag, "_valid"}, 32'(xif.xfer_valid), 1);
    chk(tag, 32'(xif.xfer_periph), exp);
    xif.xfer_ready = 1; tick; xif.xfer_ready = 0;
    repeat (dly) tick;
    xif.xfer_done = 1; xif.xfer_err = e; err_clr = ec; tick;
    xif.xfer_done = 0; xif.xfer_err = 0; err_clr = 0;
    chk({tag, "_clr"}, 32'(clr), bitv(exp));
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset;
    reset = 0;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_valid", 32'(xif.xfer_valid), 0);
    chk("rst_periph", 32'(xif.xfer_periph), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_err", 32'(err_status), 0);
    reset = 1;
    // single request, engine always ready
    mask = '1; enable = 1; xif.xfer_ready = 1; req[5] = 1;
    tick;
    chk("t1_valid", 32'(xif.xfer_valid), 1);
    chk("t1_periph", 32'(xif.xfer_periph), 5);
    tick;
    chk("t1_vdrop", 32'(xif.xfer_valid), 0);
    xif.xfer_ready = 0;
    tick; tick;
    xif.xfer_done = 1; tick; xif.xfer_done = 0;
    chk("t1_clr", 32'(clr), bitv(5));
    req[5] = 0; tick;
    chk("t1_clr_end", 32'(clr), 0);
    chk("t1_idle", 32'(idle), 1);
    // round robin with wrap through index 1
    do_reset;
    req[3] = 1; req[7] = 1; req[31] = 1;
    xfer("rr0", 3, 2, 0, 0);
    xfer("rr1", 7, 2, 0, 0);
    xfer("rr2", 31, 2, 0, 0);
    xfer("rr3", 3, 2, 0, 0);
    req = '0; tick;
    // holdoff: a still-held request waits one IDLE cycle after its clear
    req[4] = 1;
    xfer("ho0", 4, 0, 0, 0);
    tick;
    chk("ho_gap", 32'(xif.xfer_valid), 0);
    tick;
    chk("ho_next", 32'(xif.xfer_valid), 1);
    xfer("ho1", 4, 0, 0, 0);
    req = '0;
    // backpressure: no withdrawal while waiting for ready
    req[2] = 1; tick;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) req[2] = 0;
      if (c == 6) enable = 0;
      chk("bp_hold", 32'({xif.xfer_valid, xif.xfer_periph}), 32'h22);
      tick;
    end
    xif.xfer_ready = 1; tick; xif.xfer_ready = 0;
    chk("bp_busy", 32'(xif.xfer_valid), 0);
    xif.xfer_done = 1; tick; xif.xfer_done = 0;
    chk("bp_clr", 32'(clr), bitv(2));
    tick; enable = 1;
    // error flag and its clear
    req[6] = 1;
    xfer("er0", 6, 1, 1, 0);
    req = '0;
    chk("er_set", 32'(err_status), 1);
    tick; tick;
    chk("er_hold", 32'(err_status), 1);
    err_clr = 1; tick; err_clr = 0;
    chk("er_clr", 32'(err_status), 0);
    req[10] = 1;
    xfer("er1", 10, 0, 1, 0);
    req = '0; tick;
    req[11] = 1;
    xfer("er2", 11, 0, 1, 1);
    req = '0;
    chk("er_prio", 32'(err_status), 1);
    err_clr = 1; tick; err_clr = 0;
    chk("er_clr2", 32'(err_status), 0);
    // masked line never granted
    mask[9] = 0; req[9] = 1;
    repeat (8) tick;
    chk("mask_idle", 32'(idle), 1);
    chk("mask_valid", 32'(xif.xfer_valid), 0);
    req = '0; mask = '1;
    // stray done in IDLE
    xif.xfer_done = 1; tick; xif.xfer_done = 0;
    chk("stray_idle", 32'(idle), 1);
    chk("stray_clr", 32'(clr), 0);
    // asynchronous reset while BUSY on 12
    do_reset;
    req[12] = 1; req[20] = 1;
    tick;
    chk("rb_grant", 32'(xif.xfer_periph), 12);
    xif.xfer_ready = 1; tick; xif.xfer_ready = 0;
    chk("rb_busy", 32'(idle), 0);
    #2 reset = 0;
    #1;
    chk("rb_valid", 32'(xif.xfer_valid), 0);
    chk("rb_periph", 32'(xif.xfer_periph), 0);
    chk("rb_clr", 32'(clr), 0);
    chk("rb_idle", 32'(idle), 1);
    reset = 1;
    xfer("rb_first", 12, 0, 0, 0);
    req = '0; tick;
`ifdef DMA_SCHED_TIMEOUT_EN
    // watchdog with TIMEOUT_W=4: 15 BUSY cycles then forced clear
    req[8] = 1; tick;
    chk("to_valid", 32'(xif.xfer_periph), 8);
    xif.xfer_ready = 1; tick; xif.xfer_ready = 0;
    repeat (14) tick;
    chk("to_busy_clr", 32'(clr), 0);
    chk("to_busy", 32'(idle), 0);
    tick;
    chk("to_clr", 32'(clr), bitv(8));
    chk("to_err", 32'(err_status), 1);
    req = '0; tick;
    xif.xfer_done = 1; tick; xif.xfer_done = 0;
    chk("to_stray", 32'(idle), 1);
    chk("to_stray_clr", 32'(clr), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_periph_req_sched.md
Name: dma_periph_req_sched

Overview:
- Round-robin scheduler that shares one DMA channel engine among up to 31 peripheral request lines.
- Sits between the peripheral handshake pins (periph_*_req / periph_*_clr) and the channel engine that drives the AXI64 master port.
- Instantiated once for the TX request set and once for the RX request set.
- Grants one peripheral at a time, hands its index to the engine, waits for completion, then pulses that peripheral's clear line.

Parameters:
- NUM_PERIPH, 31, number of request lines; vectors are indexed [NUM_PERIPH:1], and index 0 is never used.
- IDX_W, 5, width of the peripheral index; must satisfy 2^IDX_W > NUM_PERIPH.
- TIMEOUT_W, 8, width of the watchdog counter; used only when DMA_SCHED_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when high, new grants are allowed.
- req_mask  in  [NUM_PERIPH:1]  1 = request line enabled (APB-configured).
- periph_req  in  [NUM_PERIPH:1]  level requests from peripherals.
- periph_clr  out  [NUM_PERIPH:1]  one-cycle clear pulse, at most one bit set.
- xfer_valid  out  1  transfer request to the channel engine.
- xfer_ready  in  1  engine accepts the request.
- xfer_periph  out  IDX_W  granted peripheral index, range 1..NUM_PERIPH.
- xfer_done  in  1  one-cycle pulse: transfer complete.
- xfer_err  in  1  qualifies xfer_done: the transfer ended with an AXI error response.
- err_clr  in  1  clears err_status.
- err_status  out  1  sticky error flag.
- idle  out  1  high when the FSM is in IDLE.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0 except idle=1; FSM enters IDLE; round-robin pointer last_gnt=NUM_PERIPH, so the first search starts at index 1.
- pend = periph_req & req_mask & ~holdoff.
  - holdoff is a one-hot of the last cleared index, valid only in the first IDLE cycle after CLR; otherwise 0.
- IDLE:
  - If enable=1 and pend!=0, select the first set bit of pend scanning last_gnt+1 upward, wrapping NUM_PERIPH -> 1.
  - Register the selected index into xfer_periph, set last_gnt to it, set xfer_valid=1 on the next edge, and go to ISSUE.
  - Latency from request sampled to xfer_valid high is 1 cycle.
- ISSUE:
  - xfer_valid stays high and xfer_periph stays stable until xfer_ready=1. No withdrawal, even if periph_req drops or enable goes low.
  - On the xfer_ready cycle: xfer_valid goes to 0 on the next edge and the FSM goes to BUSY.
  - If xfer_done is also high in that same cycle, go directly to CLR.
- BUSY:
  - Wait for xfer_done=1, then go to CLR.
  - xfer_done while in IDLE is ignored.
- CLR:
  - periph_clr[xfer_periph]=1 for exactly one cycle.
  - If the completing done had xfer_err=1, err_status is set.
  - Next state is IDLE, with holdoff active for 1 cycle.
- err_status:
  - Set has priority over err_clr when both occur in the same cycle.
  - Cleared only by err_clr.
- enable low:
  - Any in-flight grant completes normally through CLR.
  - No new grant is issued until enable=1.
- Masking during BUSY (req_mask bit cleared for the active peripheral) has no effect on the current transfer.
- Full load (all 31 requests held): grants rotate 1,2,...,31,1; each peripheral waits at most 30 other transfers.
- Throughput: back-to-back grants need a minimum of 1 IDLE cycle between CLR and the next xfer_valid.

Optional Feature:
- DMA_SCHED_TIMEOUT_EN defined:
  - A TIMEOUT_W counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches 2^TIMEOUT_W-1 without xfer_done, the FSM goes to CLR, periph_clr is pulsed, and err_status is set.
  - A later stray xfer_done is ignored.
- Not defined: no counter is built; BUSY waits indefinitely for xfer_done.

Test Plan:
- Single request: reset released, mask=all-1, periph_req[5]=1, xfer_ready held 1, xfer_done 3 cycles later -> xfer_valid for 1 cycle with xfer_periph=5, then periph_clr[5] pulse 1 cycle after done, then idle=1.
- Round robin: periph_req[3], [7] and [31] held, engine always ready, done after 2 cycles -> grant order 3,7,31,3; the 31->3 step wraps through index 1.
- Backpressure: xfer_ready=0 for 10 cycles, periph_req[2] dropped at cycle 4 -> xfer_valid and xfer_periph=2 stable for all 10 cycles; grant completes when xfer_ready rises.
- Error and mask: xfer_done with xfer_err=1 -> err_status=1 persists until err_clr; req_mask[9]=0 with periph_req[9]=1 -> never granted; err_clr and a new error in the same cycle -> err_status stays 1.
- Reset mid-BUSY: assert reset while BUSY on index 12 -> all outputs 0 and idle=1 immediately; after release with periph_req[12] still held, index 12 is granted first.
- With DMA_SCHED_TIMEOUT_EN and TIMEOUT_W=4: no xfer_done -> after 15 BUSY cycles, periph_clr pulses and err_status=1.
